led_pattern_ctrl: RTL
=====================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter pLedWidth, default 8, SHALL set the LED output width; legal values are 2 or more.
REQ-002 Parameter pSwWidth, default 4, SHALL set the width of each switch bus; legal values are 2 or more.
REQ-003 Parameter pDebounceCycles, default 65536, SHALL set the number of stable cycles needed to accept a switch change; legal values are 1 or more.
REQ-004 Parameter pTickDiv, default 2500000, SHALL set the base tick period in clocks; legal values are 1 or more.
REQ-005 iSysClk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 iSysRstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 iUserDipSw, input, pSwWidth bits: DIP switches, asynchronous to iSysClk.
REQ-008 iUserPushSw, input, pSwWidth bits: push switches, active-high, asynchronous to iSysClk.
REQ-009 oUserLed, output, pLedWidth bits: registered LED drive.
REQ-010 oMode, output, 2 bits: registered current mode.

Function
REQ-011 Each switch bit SHALL pass through a 2-FF synchroniser and then a per-bit debouncer.
REQ-012 Debouncer: the per-bit counter clears on any synced-vs-debounced mismatch change; the debounced bit SHALL update only after the synced value differs from it for pDebounceCycles consecutive cycles.
REQ-013 A pulse on any bit shorter than pDebounceCycles SHALL NOT change that bit's debounced value.
REQ-014 Rising-edge detection SHALL produce a one-cycle pulse on debounced push[0] (mode edge) and on debounced push[1] (duty edge).
REQ-015 The mode state machine SHALL have the states DIRECT=0, BLINK=1, CHASE=2, COUNT=3.
REQ-016 Each mode edge SHALL advance the mode DIRECT->BLINK->CHASE->COUNT->DIRECT; no other event SHALL change the mode.
REQ-017 The tick prescaler SHALL count 0..pTickDiv-1 and emit a one-cycle tick on the terminal count.
REQ-018 A step SHALL be issued on every (S+1)-th tick, where S = debounced dip[1:0].
REQ-019 DIRECT mode: oUserLed SHALL equal {debounced dip, debounced push}, zero-extended or truncated at the MSB to pLedWidth.
REQ-020 DIRECT mode: an input held stable SHALL appear on oUserLed exactly pDebounceCycles+3 clocks after its first sampling edge.
REQ-021 BLINK mode: all LED bits SHALL invert on each step.
REQ-022 CHASE mode: a one-hot pattern SHALL rotate left by one bit per step, wrapping from the MSB to bit 0.
REQ-023 COUNT mode: a binary value SHALL increment by 1 per step, wrapping from all-ones to 0.
REQ-024 On entry to a mode, the pattern SHALL load its entry value (BLINK all-off, CHASE 0...01, COUNT 0), and the tick prescaler and step counter SHALL clear.
REQ-025 If a mode edge and a step occur in the same cycle, the mode change SHALL win and the step SHALL be discarded.
REQ-026 A change to dip[1:0] SHALL take effect at the next step-counter comparison; an in-progress count above the new S SHALL wrap the step counter to 0 without issuing a step.

Reset
REQ-027 While iSysRstn=0, all flops SHALL be held at reset values: oUserLed=0, oMode=DIRECT, synchronisers/debounced=0, counters=0, duty=3.
REQ-028 Reset asserted mid-operation SHALL take effect immediately, with no clock required.
REQ-029 After deassertion, the first mode edge SHALL NOT be taken before switch state has been debounced.

Configuration
REQ-030 With macro LED_PWM_EN defined: a 2-bit duty register d is stepped by each duty edge, wrapping 3->0.
REQ-031 With LED_PWM_EN defined: a free-running 2-bit counter c gates oUserLed to 0 whenever c>d, giving 25/50/75/100% brightness; reset d=3 (100%).
REQ-032 Without LED_PWM_EN: the duty logic SHALL be absent, push[1] SHALL affect only the DIRECT display, and oUserLed SHALL be ungated.

Verification (pLedWidth=8, pSwWidth=4, pDebounceCycles=3, pTickDiv=4)
REQ-033 Reset, then dip=4'hA, push=0 -> oUserLed=8'hA0 exactly 6 clocks after the first sampling edge; oMode=0.
REQ-034 push[0] high 2 clocks -> mode unchanged; push[0] high 10 clocks -> oMode=1, and oUserLed=8'h00 then 8'hFF after 4 clocks (dip[1:0]=2'b10 gives 12 clocks).
REQ-035 CHASE with dip[1:0]=0 -> oUserLed 01,02,...,80,01 stepping every 4 clocks, including the wrap.
REQ-036 COUNT seeded near the end -> FE,FF,00 wrap; a mode edge on a step cycle -> oMode=0 and no increment.
REQ-037 LED_PWM_EN defined, one duty edge (d=0) in BLINK-on -> oUserLed=FF for 1 of every 4 clocks; macro undefined -> FF constant.
REQ-038 iSysRstn pulsed low with no clock edge mid-COUNT -> oUserLed=0 and oMode=0 immediately.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: synchronised, debounced DIP/push switches select one of four LED modes (direct, blink, chase, count).
// Defining LED_PWM_EN adds a push[1]-stepped duty register that gates the LEDs for 25/50/75/100% brightness.

module led_pattern_ctrl #(
  parameter int pLedWidth       = 8,
  parameter int pSwWidth        = 4,
  parameter int pDebounceCycles = 65536,
  parameter int pTickDiv        = 2500000
) (
  input  logic                 iSysClk,
  input  logic                 iSysRstn,
  input  logic [pSwWidth-1:0]  iUserDipSw,
  input  logic [pSwWidth-1:0]  iUserPushSw,
  output logic [pLedWidth-1:0] oUserLed,
  output logic [1:0]           oMode
);

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    BLINK  = 2'd1,
    CHASE  = 2'd2,
    COUNT  = 2'd3
  } modeE;

  localparam int cSwTotal = 2 * pSwWidth;
  localparam int cDebW    = (pDebounceCycles > 1) ? $clog2(pDebounceCycles) : 1;
  localparam int cTickW   = (pTickDiv > 1) ? $clog2(pTickDiv) : 1;
  localparam int cCopyW   = (pLedWidth < cSwTotal) ? pLedWidth : cSwTotal;

  localparam logic [cDebW-1:0]     cDebLast   = cDebW'(pDebounceCycles - 1);
  localparam logic [cTickW-1:0]    cTickLast  = cTickW'(pTickDiv - 1);
  localparam logic [pLedWidth-1:0] cChaseSeed = pLedWidth'(1);

  // Switch bus layout: dip in the upper half, push in the lower half.
  logic [cSwTotal-1:0] swRaw;
  logic [cSwTotal-1:0] swMeta;
  logic [cSwTotal-1:0] swSync;
  logic [cSwTotal-1:0] swDeb;

  assign swRaw = {iUserDipSw, iUserPushSw};

  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value of the one before it.
      swMeta <= swRaw;
      swSync <= swMeta;
    end
  end

  for (genvar b = 0; b < cSwTotal; b++) begin : gDebounce
    logic [cDebW-1:0] stableCnt;
    logic             debBit;

    always_ff @(posedge iSysClk or negedge iSysRstn) begin
      if (!iSysRstn) begin
        stableCnt <= '0;
        debBit    <= 1'b0;
      end else if (swSync[b] == debBit) begin
        stableCnt <= '0;
      end else if (stableCnt == cDebLast) begin
        stableCnt <= '0;
        debBit    <= swSync[b];
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end

    assign swDeb[b] = debBit;
  end

  logic       modePrev;
  logic       modeEdge;
  logic [1:0] stepSel;

  assign modeEdge = swDeb[0] & ~modePrev;
  assign stepSel  = swDeb[pSwWidth+1:pSwWidth];

  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) modePrev <= 1'b0;
    else           modePrev <= swDeb[0];
  end

  logic [cTickW-1:0] tickCnt;
  logic [1:0]        stepCnt;
  logic              tick;
  logic              step;

  assign tick = (tickCnt == cTickLast);
  assign step = tick && (stepCnt == stepSel);

  // A step count left above a freshly lowered select wraps to 0 silently on the next tick.
  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      tickCnt <= '0;
      stepCnt <= '0;
    end else if (modeEdge) begin
      tickCnt <= '0;
      stepCnt <= '0;
    end else begin
      tickCnt <= tick ? '0 : tickCnt + 1'b1;
      if (tick) stepCnt <= (stepCnt >= stepSel) ? 2'd0 : stepCnt + 2'd1;
    end
  end

  modeE                 modeQ;
  modeE                 modeD;
  logic [pLedWidth-1:0] patQ;
  logic [pLedWidth-1:0] patD;
  logic [pLedWidth-1:0] directView;
  logic [pLedWidth-1:0] displayD;
  logic [pLedWidth-1:0] ledD;
  logic                 ledGate;

  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      modeQ <= DIRECT;
      patQ  <= '0;
    end else begin
      modeQ <= modeD;
      patQ  <= patD;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value held, which would infer a latch.
    modeD      = modeQ;
    patD       = patQ;
    directView = '0;
    displayD   = patQ;

    if (modeEdge) begin
      unique case (modeQ)
        DIRECT:  modeD = BLINK;
        BLINK:   modeD = CHASE;
        CHASE:   modeD = COUNT;
        COUNT:   modeD = DIRECT;
        default: modeD = DIRECT;
      endcase
    end

    // Mode entry wins over a coincident step.
    if (modeEdge) begin
      patD = (modeD == CHASE) ? cChaseSeed : '0;
    end else if (step) begin
      unique case (modeQ)
        BLINK:   patD = ~patQ;
        CHASE:   patD = {patQ[pLedWidth-2:0], patQ[pLedWidth-1]};
        COUNT:   patD = patQ + 1'b1;
        default: patD = patQ;
      endcase
    end

    for (int i = 0; i < cCopyW; i++) directView[i] = swDeb[i];

    if (modeQ == DIRECT) displayD = directView;
  end

`ifdef LED_PWM_EN
  logic       dutyPrev;
  logic       dutyEdge;
  logic [1:0] dutyQ;
  logic [1:0] pwmCnt;

  assign dutyEdge = swDeb[1] & ~dutyPrev;

  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      dutyPrev <= 1'b0;
      dutyQ    <= 2'd3;
      pwmCnt   <= 2'd0;
    end else begin
      dutyPrev <= swDeb[1];
      pwmCnt   <= pwmCnt + 2'd1;
      if (dutyEdge) dutyQ <= dutyQ + 2'd1;
    end
  end

  assign ledGate = (pwmCnt > dutyQ);
`else
  assign ledGate = 1'b0;
`endif

  assign ledD = ledGate ? '0 : displayD;

  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) oUserLed <= '0;
    else           oUserLed <= ledD;
  end

  assign oMode = modeQ;

endmodule
